// File: rtl/opb_region_decoder.sv
// opb_region_decoder: OPB window decoder, one-hot strobes, registered read return.
// Define DEC_ERR_CAPTURE_EN to build the first-faulting-address capture.
module opb_region_decoder #(
  parameter int NUM_REGIONS = 8,
  parameter int ADDR_W = 20,
  parameter int DATA_W = 32,
  parameter int RD_LAT = 1,
  parameter logic [NUM_REGIONS*ADDR_W-1:0] REGION_BASE = '0,
  parameter logic [NUM_REGIONS*ADDR_W-1:0] REGION_SIZE =
    (NUM_REGIONS*ADDR_W)'(64),
  parameter logic [DATA_W-1:0] DEFAULT_DATA = DATA_W'(32'hDEAD_BEEF)
) (
  input  logic                          OPB_CLK,
  input  logic                          OPB_RST_N,
  input  logic                          DEC_RE,
  input  logic                          DEC_WE,
  input  logic [31:0]                   DEC_ADDR,
  input  logic [NUM_REGIONS*DATA_W-1:0] RD_DATA_IN,
  output logic [NUM_REGIONS-1:0]        REG_RE,
  output logic [NUM_REGIONS-1:0]        REG_WE,
  output logic [DATA_W-1:0]             DEC_DO,
  output logic                          DEC_ACK,
  output logic                          DEC_ERR,
  output logic                          DEC_BUSY,
  output logic [ADDR_W-1:0]             ERR_ADDR,
  output logic                          ERR_VALID,
  input  logic                          ERR_CLR
);

  localparam int IDX_W = (NUM_REGIONS > 1) ? $clog2(NUM_REGIONS) : 1;

  typedef enum logic {IDLE, RD_WAIT} state_t;

  state_t state_q, state_d;

  logic [ADDR_W-1:0] addr;
  logic [ADDR_W:0]   win_lo, win_sz, win_hi;
  logic              hit;
  logic [IDX_W-1:0]  hit_idx;
  logic [NUM_REGIONS-1:0] onehot;

  logic rd_go, wr_go, bad_go, done;
  logic err_d;

  logic [IDX_W-1:0]  rd_idx_q;
  logic              rd_hit_q;
  logic [3:0]        lat_q;
  logic [IDX_W-1:0]  sel_idx;
  logic              sel_hit;
  logic [DATA_W-1:0] rd_sel;

  logic unused_addr;

  assign addr = DEC_ADDR[ADDR_W-1:0];
  assign unused_addr = ^DEC_ADDR[31:ADDR_W];

  // Window match, scanned high to low so the lowest index wins.
  always_comb begin
    hit = 1'b0;
    hit_idx = '0;
    win_lo = '0;
    win_sz = '0;
    win_hi = '0;
    for (int i = NUM_REGIONS - 1; i >= 0; i--) begin
      win_lo = {1'b0, REGION_BASE[i*ADDR_W +: ADDR_W]};
      win_sz = {1'b0, REGION_SIZE[i*ADDR_W +: ADDR_W]};
      win_hi = win_lo + win_sz;
      if (win_sz != '0 && {1'b0, addr} >= win_lo &&
          {1'b0, addr} < win_hi) begin
        hit = 1'b1;
        hit_idx = IDX_W'(i);
      end
    end
  end

  assign onehot = hit ? (NUM_REGIONS'(1) << hit_idx) : '0;

  assign rd_go  = (state_q == IDLE) & DEC_RE & ~DEC_WE;
  assign wr_go  = (state_q == IDLE) & DEC_WE & ~DEC_RE;
  assign bad_go = (state_q == IDLE) & DEC_RE & DEC_WE;

  assign REG_RE = rd_go ? onehot : '0;
  assign REG_WE = wr_go ? onehot : '0;

  assign sel_idx = (state_q == IDLE) ? hit_idx : rd_idx_q;
  assign sel_hit = (state_q == IDLE) ? hit : rd_hit_q;

  // Read data mux for the region being completed.
  always_comb begin
    rd_sel = '0;
    for (int i = 0; i < NUM_REGIONS; i++) begin
      if (sel_idx == IDX_W'(i)) rd_sel = RD_DATA_IN[i*DATA_W +: DATA_W];
    end
  end

  // Next state and completion; single-cycle reads never leave IDLE.
  always_comb begin
    state_d = state_q;
    done = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (rd_go) begin
          if (RD_LAT > 1) state_d = RD_WAIT;
          else done = 1'b1;
        end
      end
      RD_WAIT: begin
        if (lat_q == 4'd1) begin
          state_d = IDLE;
          done = 1'b1;
        end
      end
    endcase
  end

  assign err_d = (done & ~sel_hit) | (wr_go & ~hit) | bad_go;

  // State register.
  always_ff @(posedge OPB_CLK or negedge OPB_RST_N) begin
    if (!OPB_RST_N) state_q <= IDLE;
    else state_q <= state_d;
  end

  // Handshake outputs, latched read context and read data return.
  always_ff @(posedge OPB_CLK or negedge OPB_RST_N) begin
    if (!OPB_RST_N) begin
      DEC_ACK  <= 1'b0;
      DEC_ERR  <= 1'b0;
      DEC_BUSY <= 1'b0;
      DEC_DO   <= '0;
      rd_idx_q <= '0;
      rd_hit_q <= 1'b0;
      lat_q    <= '0;
    end else begin
      DEC_ACK  <= done | wr_go | bad_go;
      DEC_ERR  <= err_d;
      DEC_BUSY <= (state_d == RD_WAIT);
      if (rd_go) begin
        rd_idx_q <= hit_idx;
        rd_hit_q <= hit;
        lat_q    <= 4'(RD_LAT - 1);
      end else if (state_q == RD_WAIT) begin
        lat_q <= lat_q - 4'd1;
      end
      if (done) DEC_DO <= sel_hit ? rd_sel : DEFAULT_DATA;
    end
  end

`ifdef DEC_ERR_CAPTURE_EN
  logic [ADDR_W-1:0] rd_addr_q;
  logic [ADDR_W-1:0] fault_addr;

  assign fault_addr = (state_q == RD_WAIT) ? rd_addr_q : addr;

  // First-error capture; a coincident new error beats a clear.
  always_ff @(posedge OPB_CLK or negedge OPB_RST_N) begin
    if (!OPB_RST_N) begin
      rd_addr_q <= '0;
      ERR_ADDR  <= '0;
      ERR_VALID <= 1'b0;
    end else begin
      if (rd_go) rd_addr_q <= addr;
      if (err_d && (!ERR_VALID || ERR_CLR)) begin
        ERR_ADDR  <= fault_addr;
        ERR_VALID <= 1'b1;
      end else if (ERR_CLR) begin
        ERR_VALID <= 1'b0;
      end
    end
  end
`else
  logic unused_clr;

  assign unused_clr = ERR_CLR;
  assign ERR_ADDR = '0;
  assign ERR_VALID = 1'b0;
`endif

endmodule
